// File: rtl/enc_session_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | enc_session_arbiter_if                                                 |
// | Requester-side and engine-side bus of the encryption session arbiter.  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface enc_session_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_validIn;
    logic [8*NREQ-1:0] req_plainByte;
    logic [NREQ-1:0]   grant;
    logic              busy;

    logic              eng_encRqst;
    logic              eng_validIn;
    logic [7:0]        eng_plainByte;
    logic              eng_rst;
    logic [7:0]        eng_encryptByte;
    logic              eng_validOut;
    logic              eng_done;

    logic [7:0]        out_byte;
    logic              out_valid;
    logic [IDW-1:0]    out_id;
    logic              sess_done;
    logic              sess_err;

    // Arbiter view
    modport slave (
        input  req, req_validIn, req_plainByte,
        input  eng_encryptByte, eng_validOut, eng_done,
        output grant, busy,
        output eng_encRqst, eng_validIn, eng_plainByte, eng_rst,
        output out_byte, out_valid, out_id, sess_done, sess_err
    );

    // Requesters plus engine view
    modport master (
        output req, req_validIn, req_plainByte,
        output eng_encryptByte, eng_validOut, eng_done,
        input  grant, busy,
        input  eng_encRqst, eng_validIn, eng_plainByte, eng_rst,
        input  out_byte, out_valid, out_id, sess_done, sess_err
    );
endinterface
`default_nettype wire

// File: rtl/enc_session_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | enc_session_arbiter                                                    |
// | Round-robin owner selection and session sequencing for a shared        |
// | encryption engine, with a no-progress watchdog.  Rev 1.0               |
// +------------------------------------------------------------------------+
module enc_session_arbiter #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  wire logic            clk,
    input  wire logic            rst,
    enc_session_arbiter_if.slave bus
);
    localparam int             WDW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] C_WD_LIMIT = WDW'(TIMEOUT_CYC);
    localparam logic [IDW-1:0] C_LAST_ID  = IDW'(NREQ - 1);
    localparam logic [IDW:0]   C_NREQ     = (IDW + 1)'(NREQ);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NREQ-1:0] r_grant;
    logic [IDW-1:0]  r_owner;
    logic [IDW-1:0]  r_rr_ptr;
    logic [WDW-1:0]  r_wd;

    logic            w_found;
    logic [IDW-1:0]  w_winner;
    logic [IDW:0]    w_cand;
    logic            w_sel_valid;
    logic [7:0]      w_sel_byte;
    logic            w_timeout;
    logic [IDW-1:0]  w_next_ptr;

    // Scan upward from rr_ptr with wrap; first hit wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = {1'b0, r_rr_ptr} + (IDW + 1)'(i);
            if (w_cand >= C_NREQ) begin
                w_cand = w_cand - C_NREQ;
            end
            if (!w_found && bus.req[w_cand[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_byte  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IDW'(i)) begin
                w_sel_valid = bus.req_validIn[i];
                w_sel_byte  = bus.req_plainByte[8*i +: 8];
            end
        end
    end

    assign w_timeout  = (r_wd == C_WD_LIMIT);
    assign w_next_ptr = (r_owner == C_LAST_ID) ? '0 : r_owner + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_wd     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= NREQ'(1) << w_winner;
                        r_owner <= w_winner;
                    end
                end
                S_START: begin
                    r_wd <= '0;
                end
                S_RUN: begin
                    if (bus.eng_validOut) begin
                        r_wd <= '0;
                    end else if (!w_timeout) begin
                        r_wd <= r_wd + WDW'(1);
                    end
                end
                S_RELEASE, S_ABORT: begin
                    r_grant  <= '0;
                    r_rr_ptr <= w_next_ptr;
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        bus.eng_encRqst   = 1'b0;
        bus.eng_validIn   = 1'b0;
        bus.eng_plainByte = '0;
        bus.out_valid     = 1'b0;
        bus.eng_rst       = 1'b0;
        bus.sess_done     = 1'b0;
        bus.sess_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                bus.eng_encRqst = 1'b1;
                w_state_nxt     = S_RUN;
            end
            S_RUN: begin
                bus.eng_validIn   = w_sel_valid;
                bus.eng_plainByte = w_sel_byte;
                bus.out_valid     = bus.eng_validOut;
                // A completing engine beats a watchdog expiring in the same cycle.
                if (bus.eng_done) begin
                    w_state_nxt = S_RELEASE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ABORT;
                end
            end
            S_RELEASE: begin
                bus.sess_done = 1'b1;
                w_state_nxt   = S_IDLE;
            end
            S_ABORT: begin
                bus.eng_rst  = 1'b1;
                bus.sess_err = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.grant    = r_grant;
    assign bus.out_id   = r_owner;
    assign bus.out_byte = bus.eng_encryptByte;
endmodule
`default_nettype wire

// File: tb/tb_enc_session_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_enc_session_arbiter                                                 |
// | Vector table, directed corner sequences and random traffic vs model.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_enc_session_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    enc_session_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    enc_session_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NREQ-1:0] vin;
    logic [7:0]      pb [NREQ];
    always_comb begin
        bus.req_validIn = vin;
        for (int i = 0; i < NREQ; i++) bus.req_plainByte[8*i +: 8] = pb[i];
    end

    typedef struct packed {
        logic [3:0] grant;
        logic       busy, rqst, erst, evin;
        logic [7:0] epb;
        logic       ov;
        logic [7:0] ob;
        logic [1:0] id;
        logic       sd, se;
    } obs_t;

    obs_t dut_o;
    assign dut_o = {bus.grant, bus.busy, bus.eng_encRqst, bus.eng_rst, bus.eng_validIn,
                    bus.eng_plainByte, bus.out_valid, bus.out_byte, bus.out_id,
                    bus.sess_done, bus.sess_err};

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    obs_t last_obs;
    bit   in_run;

    // Session model: m_act = owner holds engine, m_age 0 = start cycle,
    // m_tail 1/2 = closing cycle after completion / abort.
    bit m_act;
    int m_own, m_age, m_wd, m_tail, m_ptr, m_lastid;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic obs_t model_expect();
        obs_t e;
        e    = '0;
        e.ob = bus.eng_encryptByte;
        e.id = 2'(m_lastid);
        if (m_act || m_tail != 0) begin
            e.grant = 4'(1 << m_own);
            e.busy  = 1'b1;
        end
        if (m_act && m_age == 0) e.rqst = 1'b1;
        if (m_act && m_age >= 1) begin
            e.evin = vin[m_own];
            e.epb  = pb[m_own];
            e.ov   = bus.eng_validOut;
        end
        if (m_tail == 1) e.sd = 1'b1;
        if (m_tail == 2) begin
            e.se   = 1'b1;
            e.erst = 1'b1;
        end
        return e;
    endfunction

    task automatic model_clock();
        bit f;
        int c;
        f = 1'b0;
        if (rst) begin
            m_act = 0; m_tail = 0; m_ptr = 0; m_lastid = 0; m_wd = 0; m_age = 0; m_own = 0;
        end else if (m_tail != 0) begin
            m_tail = 0;
            m_ptr  = (m_own + 1) % NREQ;
        end else if (!m_act) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!f && bus.req[c]) begin
                    f     = 1'b1;
                    m_own = c;
                end
            end
            if (f) begin
                m_act = 1; m_age = 0; m_lastid = m_own;
            end
        end else if (m_age == 0) begin
            m_age = 1;
            m_wd  = 0;
        end else if (bus.eng_done) begin
            m_act = 0; m_tail = 1;
        end else if (m_wd >= TO) begin
            m_act = 0; m_tail = 2;
        end else begin
            m_wd  = bus.eng_validOut ? 0 : ((m_wd < TO) ? m_wd + 1 : TO);
            m_age = m_age + 1;
        end
    endtask

    task automatic step();
        obs_t e;
        @(negedge clk);
        e        = model_expect();
        last_obs = dut_o;
        in_run   = m_act && (m_age >= 1);
        check("model", 64'(last_obs), 64'(e));
        @(posedge clk);
        #1;
        model_clock();
        cyc++;
    endtask

    task automatic eng_idle();
        bus.eng_validOut = 1'b0; bus.eng_encryptByte = 8'h00; bus.eng_done = 1'b0;
    endtask

    // Engine that streams bytes and finishes on a chosen RUN cycle.
    task automatic eng_auto(input int done_age);
        eng_idle();
        if (m_act && m_age >= 1) begin
            bus.eng_validOut    = (m_age < done_age);
            bus.eng_encryptByte = 8'(8'hC0 + m_age);
            bus.eng_done        = (m_age == done_age);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '0; vin = '0;
        for (int i = 0; i < NREQ; i++) pb[i] = 8'h00;
        eng_idle();
        step(); step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       vo;
        logic [7:0] eb;
        logic       dn;
        logic [3:0] x_grant;
        logic       x_busy, x_rqst, x_ov;
        logic [1:0] x_id;
        logic       x_sd;
    } vec_t;
    vec_t tbl [9];

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int gq [$];
        int n_rq, n_sd, n_se, n_er, n_aa, n_ev, n_v1, c_s, c_e, g2, bud;
        logic [3:0] exp_g [4];

        tbl[0] = '{4'b0100, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1] = '{4'b0100, 1'b0, 8'h00, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
        tbl[2] = '{4'b0100, 1'b1, 8'h11, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[3] = '{4'b0100, 1'b1, 8'h22, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[4] = '{4'b0100, 1'b1, 8'h33, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[5] = '{4'b0100, 1'b1, 8'h44, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[6] = '{4'b0100, 1'b1, 8'h55, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0};
        tbl[7] = '{4'b0000, 1'b0, 8'h00, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
        tbl[8] = '{4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};

        m_act = 0; m_tail = 0; m_ptr = 0; m_lastid = 0; m_wd = 0; m_age = 0; m_own = 0;
        do_reset();
        check("reset_state", 64'(last_obs), 64'(0));

        // Single requester, 5-byte packet
        for (int i = 0; i < 9; i++) begin
            bus.req = tbl[i].req; bus.eng_validOut = tbl[i].vo;
            bus.eng_encryptByte = tbl[i].eb; bus.eng_done = tbl[i].dn;
            step();
            check($sformatf("tbl_row%0d", i),
                  64'({last_obs.grant, last_obs.busy, last_obs.rqst, last_obs.ov, last_obs.id, last_obs.sd}),
                  64'({tbl[i].x_grant, tbl[i].x_busy, tbl[i].x_rqst, tbl[i].x_ov, tbl[i].x_id, tbl[i].x_sd}));
        end

        // Contention: grant order 0,1,3,0
        do_reset();
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
        bus.req = 4'b1011; n_rq = 0; n_sd = 0; bud = 0;
        while (bud < 100 && (gq.size() < 4 || m_act || m_tail != 0)) begin
            eng_auto(3);
            step(); bud++;
            if (last_obs.rqst) begin
                gq.push_back(int'(last_obs.grant)); n_rq++;
                if (gq.size() == 4) bus.req = '0;
            end
            if (last_obs.sd) n_sd++;
        end
        check("cont_sessions", 64'(gq.size()), 64'(4));
        for (int i = 0; i < 4 && i < gq.size(); i++)
            check($sformatf("cont_grant%0d", i), 64'(gq[i]), 64'(exp_g[i]));
        check("cont_rqst_cnt", 64'(n_rq), 64'(4));
        check("cont_done_cnt", 64'(n_sd), 64'(4));

        // Isolation: requester 0 chatters with 8'hAA during requester 1's session
        do_reset();
        bus.req = 4'b0010; pb[0] = 8'hAA; pb[1] = 8'h5A;
        n_aa = 0; n_ev = 0; n_v1 = 0;
        for (int i = 0; i < 14; i++) begin
            eng_auto(9);
            vin[0] = i[0]; vin[1] = (i % 3 == 0);
            step();
            if (last_obs.epb == 8'hAA) n_aa++;
            if (last_obs.evin) n_ev++;
            if (in_run && vin[1]) n_v1++;
        end
        bus.req = '0; vin = '0;
        check("iso_no_AA", 64'(n_aa), 64'(0));
        check("iso_validIn", 64'(n_ev), 64'(n_v1));

        // Watchdog abort with silent engine
        do_reset();
        bus.req = 4'b0101; eng_idle();
        c_s = -1; c_e = -1; n_er = 0; n_se = 0; g2 = 0; bud = 0;
        while (bud < 60 && g2 == 0) begin
            step(); bud++;
            if (last_obs.rqst && c_s < 0) c_s = cyc;
            else if (last_obs.rqst) g2 = int'(last_obs.grant);
            if (last_obs.se && c_e < 0) c_e = cyc;
            if (last_obs.se) n_se++;
            if (last_obs.erst) n_er++;
        end
        check("to_abort_delay", 64'(c_e - c_s - 1), 64'(17));
        check("to_erst_cnt", 64'(n_er), 64'(1));
        check("to_err_cnt", 64'(n_se), 64'(1));
        check("to_next_grant", 64'(g2), 64'(4'b0100));

        // eng_done coincides with watchdog expiry
        do_reset();
        bus.req = 4'b0001; n_sd = 0; n_se = 0; n_er = 0;
        for (int i = 0; i < 26; i++) begin
            eng_idle();
            if (m_act && m_age >= 1 && m_wd == TO) bus.eng_done = 1'b1;
            step();
            if (last_obs.rqst) bus.req = '0;
            if (last_obs.sd) n_sd++;
            if (last_obs.se) n_se++;
            if (last_obs.erst) n_er++;
        end
        check("tie_done", 64'(n_sd), 64'(1));
        check("tie_err", 64'(n_se), 64'(0));
        check("tie_erst", 64'(n_er), 64'(0));

        // Reset in the middle of RUN
        do_reset();
        bus.req = 4'b1000; bud = 0;
        while (bud < 20 && !(m_act && m_age >= 2)) begin
            eng_auto(50); step(); bud++;
        end
        eng_idle(); vin = '0;
        rst = 1'b1; bus.req = 4'b1110;
        step();
        rst = 1'b0;
        step();
        check("rst_mid_outputs", 64'(last_obs), 64'(0));
        step();
        check("rst_first_grant", 64'(last_obs.grant), 64'(4'b0010));

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(7) == 0) bus.req = 4'($urandom);
            vin = 4'($urandom);
            for (int k = 0; k < NREQ; k++) pb[k] = 8'($urandom);
            bus.eng_encryptByte = 8'($urandom);
            bus.eng_validOut = ((i / 200) % 2 == 0) ? ($urandom_range(1) == 0) : ($urandom_range(49) == 0);
            bus.eng_done = ($urandom_range(19) == 0);
            rst = ($urandom_range(399) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/enc_session_arbiter.md
# enc_session_arbiter

Round-robin arbiter and session sequencer that shares one LFSR packet-encryption engine among `NREQ` requesters. It accepts per-requester encryption requests and grants one requester at a time. It issues the engine's single-cycle start request and steers the granted requester's plaintext stream into the engine. Encrypted bytes come back tagged with the owner's ID. A watchdog aborts a hung session by pulsing the engine reset, then the arbiter moves to the next requester. It sits between the packet sources and the encryption datapath/sequencer pair.

## Interface
- `NREQ`, 4: number of requesters; 2..8.
- `IDW`, 2: requester ID width; equals ceil(log2(NREQ)).
- `TIMEOUT_CYC`, 1024: maximum cycles in RUN without an engine byte before abort; must be at least 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in NREQ: level request per requester.
- `req_validIn` in NREQ: per-requester plaintext byte valid.
- `req_plainByte` in 8*NREQ: per-requester plaintext; requester i uses bits [8i+7:8i].
- `grant` out NREQ: one-hot owner of the engine; all-zero when idle.
- `busy` out 1: a session is in progress (any state other than IDLE).
- `eng_encRqst` out 1: one-cycle start pulse to the engine.
- `eng_validIn` out 1: plaintext valid forwarded to the engine.
- `eng_plainByte` out 8: plaintext forwarded to the engine.
- `eng_rst` out 1: engine reset; one-cycle pulse on abort.
- `eng_encryptByte` in 8: encrypted byte from the engine.
- `eng_validOut` in 1: encrypted byte valid.
- `eng_done` in 1: engine reports the packet is complete.
- `out_byte` out 8: `eng_encryptByte`, passed through.
- `out_valid` out 1: `eng_validOut` gated by RUN.
- `out_id` out IDW: ID of the current owner.
- `sess_done` out 1: one-cycle pulse when a session completes normally.
- `sess_err` out 1: one-cycle pulse when a session is aborted by timeout.

## Operation
- **States:** IDLE, START, RUN, RELEASE, ABORT.
- **IDLE:**
  - If `req` is nonzero, select the first set bit at or after `rr_ptr`, searching upward with wrap-around.
  - Register the winner into `grant` and `out_id`, then go to START.
  - If `req` is zero, stay in IDLE.
- **START** (1 cycle): `eng_encRqst`=1, then go to RUN.
- **RUN:**
  - `eng_validIn` = `req_validIn[owner]` and `eng_plainByte` = `req_plainByte[owner]`, both combinational.
  - Non-owner inputs are ignored.
  - `out_byte`/`out_valid` follow the engine combinationally.
  - On `eng_done`=1, go to RELEASE.
  - Else if the watchdog reaches `TIMEOUT_CYC`, go to ABORT.
- **Watchdog:**
  - Counter cleared on entry to RUN and on every cycle with `eng_validOut`=1.
  - Increments on every other RUN cycle.
  - Saturates; it never wraps.
- **Simultaneous `eng_done` and timeout in the same cycle:** `eng_done` wins and the session ends as RELEASE.
- **RELEASE** (1 cycle):
  - `sess_done`=1.
  - `rr_ptr` ← owner+1, wrapping modulo NREQ.
  - `grant` cleared; go to IDLE.
- **ABORT** (1 cycle):
  - `eng_rst`=1 and `sess_err`=1.
  - `rr_ptr` ← owner+1; `grant` cleared; go to IDLE.
- **Request drops:** a `req` deasserting mid-session has no effect. A session ends only via `eng_done` or timeout.
- **Outside RUN:** `eng_validIn`=0, `eng_plainByte`=0, `out_valid`=0.
- **`eng_done` outside RUN** is ignored.
- **Reset values:**
  - State=IDLE, `rr_ptr`=0, watchdog counter=0.
  - `grant`=0, `out_id`=0, `busy`=0.
  - `eng_encRqst`=0, `eng_rst`=0, `sess_done`=0, `sess_err`=0.
- **Reset mid-session:** returns immediately to the reset state. No `sess_done` or `sess_err` is emitted, and `eng_rst` is not pulsed; the engine shares `rst`.

## Timing
- `req` sampled at edge N in IDLE: `grant`/`busy` valid in cycle N+1 (START) with `eng_encRqst`=1; RUN begins in N+2.
- Data path latency through the arbiter is 0 cycles in both directions.
- `eng_done` seen at edge M: RELEASE in M+1, IDLE in M+2. The earliest next grant is registered at edge M+2, so its START is cycle M+3.
- Minimum idle gap between sessions is 2 cycles (RELEASE + IDLE).
- Abort: the watchdog hits `TIMEOUT_CYC` at edge T; ABORT in T+1; IDLE in T+2.

## Test plan
- **Single requester:** `req`=4'b0100 with a 5-byte packet.
  - START occurs 1 cycle after the request with one `eng_encRqst` pulse.
  - `grant`=0100, `out_id`=2, the 5 engine bytes are forwarded, then `sess_done` pulses once.
- **Contention:** `req`=4'b1011 held throughout from reset.
  - Grant order is 0, 1, 3, 0.
  - Each session is preceded by exactly one `eng_encRqst` and followed by one `sess_done`.
- **Isolation:** during requester 1's session, toggle `req_validIn[0]` with `req_plainByte[0]`=8'hAA.
  - `eng_validIn` tracks only requester 1, and 8'hAA never appears on `eng_plainByte`.
- **Timeout:** `TIMEOUT_CYC`=16 and the engine never asserts `eng_validOut`.
  - ABORT occurs 17 cycles after RUN entry, with `eng_rst` and `sess_err` each high for 1 cycle.
  - The next pending requester is then granted.
- **Done versus timeout in the same cycle:** `sess_done`=1 and `sess_err`=0, with no `eng_rst`.
- **Reset mid-RUN:** assert `rst` for 1 cycle.
  - All outputs are 0 the next cycle and `rr_ptr`=0.
  - With `req`=4'b1110 pending, the first grant after reset is requester 1.
